// File: rtl/data_memory_pkg.sv
// Shared types and elaboration-time helpers for the data memory controller.
//   state_e    : controller state (INIT = zero-clear sweep, RUN = serving)
//   lanes()    : number of byte lanes in a word
//   *_ok()     : parameter legality checks used by the top-level generate guard
package data_memory_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  function automatic int lanes(input int data_w);
    return data_w / 8;
  endfunction

  function automatic bit data_w_ok(input int data_w);
    return (data_w > 0) && (data_w % 8 == 0);
  endfunction

  function automatic bit lat_ok(input int lat);
    return (lat == 1) || (lat == 2);
  endfunction

  function automatic bit addr_w_ok(input int addr_w, input int depth);
    return (depth > 1) && (addr_w >= $clog2(depth));
  endfunction

endpackage

// File: rtl/data_memory_bram.sv
// Plain synchronous single-port RAM with per-byte-lane write enables.
// Read-first: rdata shows the word as it was before any write on the same edge.
// No reset on storage or read register; the controller gates the output.
//   clk   : clock
//   addr  : word index
//   we    : byte-lane write enables
//   wdata : write data
//   rdata : registered read data (one cycle after addr)
module data_memory_bram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 512,
  parameter int LANES  = DATA_W / 8,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [IDX_W-1:0]  addr,
  input  logic [LANES-1:0]  we,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  (* ram_style = "block" *) logic [DATA_W-1:0] mem [DEPTH];

  logic [DATA_W-1:0] rdata_d, rdata_q;

  always_comb rdata_d = mem[addr];

  always_ff @(posedge clk) begin
    for (int i = 0; i < LANES; i++) begin
      if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
    end
    rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory_ctrl.sv
// Data memory controller: valid/ready request port in front of a block RAM.
// Zero-clears every word after reset (optional), checks address range,
// and returns exactly one response per accepted request READ_LAT cycles later.
//   clk, rst     : clock, asynchronous active-high reset
//   req_*        : request handshake (valid/ready), write flag, address, data, byte enables
//   resp_valid   : one-cycle response pulse
//   resp_rdata   : read data, zero for writes / errors / idle
//   resp_error   : request address was >= DEPTH
//   init_done    : clear sweep finished, block is serving requests
module data_memory_ctrl
  import data_memory_pkg::*;
#(
  parameter int DATA_W         = 16,
  parameter int DEPTH          = 512,
  parameter int ADDR_W         = 16,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [ADDR_W-1:0]    req_addr,
  input  logic [DATA_W-1:0]    req_wdata,
  input  logic [DATA_W/8-1:0]  req_be,
  output logic                 resp_valid,
  output logic [DATA_W-1:0]    resp_rdata,
  output logic                 resp_error,
  output logic                 init_done
);

  localparam int LANES = lanes(DATA_W);
  localparam int IDX_W = $clog2(DEPTH);
  localparam state_e RST_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
  // One bit wider than the address so DEPTH itself is representable.
  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W+1)'(DEPTH);

  if (!(data_w_ok(DATA_W) && lat_ok(READ_LAT) && addr_w_ok(ADDR_W, DEPTH))) begin : g_bad_params
    $error("data_memory_ctrl: illegal DATA_W/READ_LAT/ADDR_W/DEPTH combination");
  end

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              rdy_q, rdy_d;
  logic              s1_vld_q, s1_vld_d;
  logic              s1_err_q, s1_err_d;
  logic              s1_rd_q,  s1_rd_d;   // in-range read: RAM data is meaningful

  logic              accept, in_range;
  logic [IDX_W-1:0]  ram_addr;
  logic [LANES-1:0]  ram_we;
  logic [DATA_W-1:0] ram_wdata, ram_rdata, s1_rdata;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ram_addr  = req_addr[IDX_W-1:0];
    ram_we    = '0;
    ram_wdata = req_wdata;
    accept    = req_valid & rdy_q;
    in_range  = {1'b0, req_addr} < DEPTH_X;
    s1_vld_d  = accept;
    s1_err_d  = accept & ~in_range;
    s1_rd_d   = accept & ~req_write & in_range;
    case (state_q)
      ST_INIT: begin
        ram_addr  = cnt_q;
        ram_we    = '1;
        ram_wdata = '0;
        cnt_d     = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(DEPTH - 1)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      end
      default: begin
        if (accept && req_write && in_range) ram_we = req_be;
      end
    endcase
    // Ready/init_done are registered so they read 0 throughout reset.
    rdy_d = (state_d == ST_RUN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      rdy_q    <= 1'b0;
      s1_vld_q <= 1'b0;
      s1_err_q <= 1'b0;
      s1_rd_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdy_q    <= rdy_d;
      s1_vld_q <= s1_vld_d;
      s1_err_q <= s1_err_d;
      s1_rd_q  <= s1_rd_d;
    end
  end

  data_memory_bram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LANES  (LANES),
    .IDX_W  (IDX_W)
  ) u_bram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  // RAM output register has no reset; qualify it with the reset-able stage flag.
  assign s1_rdata = s1_rd_q ? ram_rdata : '0;

  if (READ_LAT == 2) begin : g_lat2
    logic              resp_valid_q, resp_valid_d;
    logic              resp_error_q, resp_error_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;

    always_comb begin
      resp_valid_d = s1_vld_q;
      resp_error_d = s1_err_q;
      resp_rdata_d = s1_rdata;
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        resp_valid_q <= 1'b0;
        resp_error_q <= 1'b0;
        resp_rdata_q <= '0;
      end else begin
        resp_valid_q <= resp_valid_d;
        resp_error_q <= resp_error_d;
        resp_rdata_q <= resp_rdata_d;
      end
    end

    assign resp_valid = resp_valid_q;
    assign resp_error = resp_error_q;
    assign resp_rdata = resp_rdata_q;
  end else begin : g_lat1
    assign resp_valid = s1_vld_q;
    assign resp_error = s1_err_q;
    assign resp_rdata = s1_rdata;
  end

  assign req_ready = rdy_q;
  assign init_done = rdy_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench: two controllers (READ_LAT=1 and READ_LAT=2) share one
// request stream. A vector table drives back-to-back requests; hand-written
// sequences cover the clear sweep length and reset during INIT / in flight.
module tb_data_memory_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [15:0] req_addr  = '0;
  logic [15:0] req_wdata = '0;
  logic [1:0]  req_be    = '0;

  logic        ready1, rv1, err1, done1;
  logic [15:0] rd1;
  logic        ready2, rv2, err2, done2;
  logic [15:0] rd2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  data_memory_ctrl #(.DATA_W(16), .DEPTH(512), .ADDR_W(16), .READ_LAT(1), .CLEAR_ON_RESET(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready1), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rv1), .resp_rdata(rd1), .resp_error(err1), .init_done(done1));

  data_memory_ctrl #(.DATA_W(16), .DEPTH(512), .ADDR_W(16), .READ_LAT(2), .CLEAR_ON_RESET(1)) u_dut2 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(ready2), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .resp_valid(rv2), .resp_rdata(rd2), .resp_error(err2), .init_done(done2));

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic wr, input logic [15:0] a,
                       input logic [15:0] d, input logic [1:0] be);
    req_valid = v;
    req_write = wr;
    req_addr  = a;
    req_wdata = d;
    req_be    = be;
  endtask

  // Steps until both controllers are ready (bounded); counts cycles and any responses.
  task automatic wait_ready(output int n, inout int stray);
    n = 0;
    while (!(ready1 && ready2) && n < 2000) begin
      step();
      n++;
      if (rv1 || rv2) stray++;
    end
  endtask

  initial begin
    int n;
    int stray;
    vecs[0]  = '{1'b0, 16'd511,   16'h0000, 2'b00, 16'h0000, 1'b0};
    vecs[1]  = '{1'b0, 16'd7,     16'h0000, 2'b00, 16'h0000, 1'b0};
    vecs[2]  = '{1'b1, 16'd5,     16'hBEEF, 2'b11, 16'h0000, 1'b0};
    vecs[3]  = '{1'b0, 16'd5,     16'h0000, 2'b00, 16'hBEEF, 1'b0};
    vecs[4]  = '{1'b1, 16'd5,     16'h12AB, 2'b01, 16'h0000, 1'b0};
    vecs[5]  = '{1'b0, 16'd5,     16'h0000, 2'b00, 16'hBEAB, 1'b0};
    vecs[6]  = '{1'b1, 16'd5,     16'hFFFF, 2'b00, 16'h0000, 1'b0};
    vecs[7]  = '{1'b0, 16'd5,     16'h0000, 2'b00, 16'hBEAB, 1'b0};
    vecs[8]  = '{1'b1, 16'd0,     16'h1234, 2'b11, 16'h0000, 1'b0};
    vecs[9]  = '{1'b1, 16'd512,   16'h5555, 2'b11, 16'h0000, 1'b1};
    vecs[10] = '{1'b0, 16'd512,   16'h0000, 2'b00, 16'h0000, 1'b1};
    vecs[11] = '{1'b0, 16'd0,     16'h0000, 2'b00, 16'h1234, 1'b0};
    vecs[12] = '{1'b1, 16'd1,     16'h0A0A, 2'b10, 16'h0000, 1'b0};
    vecs[13] = '{1'b1, 16'd2,     16'h2222, 2'b11, 16'h0000, 1'b0};
    vecs[14] = '{1'b1, 16'd3,     16'h3333, 2'b11, 16'h0000, 1'b0};
    vecs[15] = '{1'b0, 16'd1,     16'h0000, 2'b00, 16'h0A00, 1'b0};
    vecs[16] = '{1'b0, 16'd2,     16'h0000, 2'b00, 16'h2222, 1'b0};
    vecs[17] = '{1'b0, 16'd3,     16'h0000, 2'b00, 16'h3333, 1'b0};
    vecs[18] = '{1'b0, 16'hFFFF,  16'h0000, 2'b00, 16'h0000, 1'b1};
    vecs[19] = '{1'b1, 16'd3,     16'hABCD, 2'b10, 16'h0000, 1'b0};
    vecs[20] = '{1'b0, 16'd3,     16'h0000, 2'b00, 16'hAB33, 1'b0};

    // Reset state
    step(); step();
    chk("rst ready1", ready1, 1'b0);
    chk("rst ready2", ready2, 1'b0);
    chk("rst valid1", rv1, 1'b0);
    chk("rst valid2", rv2, 1'b0);
    chk("rst rdata1", rd1, 16'h0);
    chk("rst err2", err2, 1'b0);
    chk("rst done1", done1, 1'b0);

    // Clear sweep: requests during INIT must be ignored (write to 7 dropped).
    rst = 1'b0;
    drive(1'b1, 1'b1, 16'd7, 16'hFFFF, 2'b11);
    stray = 0;
    wait_ready(n, stray);
    chk("init cycles", n, 512);
    chk("init done1", done1, 1'b1);
    chk("init done2", done2, 1'b1);
    chk("init stray resp", stray, 0);

    // Table: back-to-back requests, LAT1 checked one edge after, LAT2 two edges after.
    for (int i = 0; i <= NV + 1; i++) begin
      if (i < NV) drive(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      else        drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
      step();
      if (i < NV) begin
        chk($sformatf("v%0d lat1 valid", i), rv1, 1'b1);
        chk($sformatf("v%0d lat1 rdata", i), rd1, vecs[i].exp_rdata);
        chk($sformatf("v%0d lat1 err", i), err1, vecs[i].exp_err);
      end else if (i == NV) begin
        chk("lat1 idle valid", rv1, 1'b0);
        chk("lat1 idle rdata", rd1, 16'h0);
      end
      if (i >= 1 && i <= NV) begin
        chk($sformatf("v%0d lat2 valid", i-1), rv2, 1'b1);
        chk($sformatf("v%0d lat2 rdata", i-1), rd2, vecs[i-1].exp_rdata);
        chk($sformatf("v%0d lat2 err", i-1), err2, vecs[i-1].exp_err);
      end else if (i == 0) begin
        chk("lat2 first edge valid", rv2, 1'b0);
      end else begin
        chk("lat2 idle valid", rv2, 1'b0);
      end
    end

    // Reset with reads in flight: nothing may be emitted afterwards.
    drive(1'b1, 1'b0, 16'd2, 16'h0, 2'b00);
    step();
    drive(1'b1, 1'b0, 16'd3, 16'h0, 2'b00);
    step();
    rst = 1'b1;
    #1;
    chk("inflight rst valid1", rv1, 1'b0);
    chk("inflight rst valid2", rv2, 1'b0);
    chk("inflight rst rdata1", rd1, 16'h0);
    chk("inflight rst ready1", ready1, 1'b0);
    stray = 0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (rv1 || rv2) stray++;
    end
    rst = 1'b0;
    // Restart sweep, then reset again at cnt=100.
    for (int k = 0; k < 100; k++) begin
      step();
      if (rv1 || rv2 || ready1 || ready2) stray++;
    end
    rst = 1'b1;
    #1;
    chk("midinit rst done1", done1, 1'b0);
    step(); step();
    rst = 1'b0;
    wait_ready(n, stray);
    chk("reinit cycles", n, 512);
    chk("reset stray resp", stray, 0);

    // Memory was cleared again.
    drive(1'b1, 1'b0, 16'd5, 16'h0, 2'b00);
    step();
    drive(1'b0, 1'b0, 16'h0, 16'h0, 2'b00);
    chk("cleared lat1 valid", rv1, 1'b1);
    chk("cleared lat1 rdata", rd1, 16'h0);
    step();
    chk("cleared lat2 valid", rv2, 1'b1);
    chk("cleared lat2 rdata", rd2, 16'h0);
    chk("cleared lat1 single pulse", rv1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
